// File: rtl/fpu_round_pkg.sv
// Shared types and constants for the double-precision round/pack back end.
// The optional flag accumulator is enabled with the FPU_ROUND_FLAGS_ACC_EN macro in the top.
package fpu_round_pkg;

  typedef enum logic [1:0] {
    RNE = 2'b00,
    RTZ = 2'b01,
    RUP = 2'b10,
    RDN = 2'b11
  } round_mode_e;

  localparam logic [10:0] EXP_MAX    = 11'h7FF;
  localparam logic [10:0] EXP_MAXFIN = 11'h7FE;
  localparam int          FRAC_W     = 52;

  // Bit positions inside the packed {overflow, underflow, inexact} flag vector.
  localparam int FLAG_IX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OV = 2;

endpackage

// File: rtl/fpu_round_incr.sv
// Rounding increment decision (fed from stage 1) and 53-bit significand increment
// with carry-out and denormal-promote detection (fed from stage 2).
module fpu_round_incr
  import fpu_round_pkg::*;
(
  input  logic [1:0]  i_round_mode,
  input  logic        i_sign,
  input  logic        i_lsb,
  input  logic        i_guard,
  input  logic        i_sticky,
  output logic        o_inc,
  input  logic [52:0] i_sig,
  input  logic        i_inc,
  input  logic        i_exp_zero,
  output logic [51:0] o_frac,
  output logic        o_carry,
  output logic        o_promote
);

  round_mode_e w_mode;
  logic [53:0] w_sum;

  assign w_mode = round_mode_e'(i_round_mode);

  always_comb begin
    o_inc = 1'b0;
    case (w_mode)
      RNE:     o_inc = i_guard & (i_sticky | i_lsb);
      RTZ:     o_inc = 1'b0;
      RUP:     o_inc = (i_guard | i_sticky) & ~i_sign;
      RDN:     o_inc = (i_guard | i_sticky) & i_sign;
      default: o_inc = 1'b0;
    endcase
  end

  // Carry out of the hidden bit means the significand was all ones: fraction wraps to 0.
  assign w_sum     = {1'b0, i_sig} + {53'b0, i_inc};
  assign o_frac    = w_sum[51:0];
  assign o_carry   = w_sum[53];
  assign o_promote = i_exp_zero & w_sum[52];

endmodule

// File: rtl/fpu_round_pack.sv
// Round/pack back end of the double multiply path: input register plus three stages.
// Optional sticky flag accumulator with flags_clr/flags_acc under FPU_ROUND_FLAGS_ACC_EN.
module fpu_round_pack
  import fpu_round_pkg::*;
#(
  parameter int EXP_W   = 12,
  parameter int MANT_W  = 56,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [1:0]        round_mode,
  input  logic              sign_in,
  input  logic [MANT_W-1:0] mantissa_in,
  input  logic [EXP_W-1:0]  exponent_in,
  input  logic              shift_inexact_in,
  output logic              out_valid,
  output logic [63:0]       result,
  output logic              out_inexact,
  output logic              out_overflow,
  output logic              out_underflow
`ifdef FPU_ROUND_FLAGS_ACC_EN
  ,
  input  logic              flags_clr,
  output logic [2:0]        flags_acc
`endif
);

  // Valid semantics: a bundle is taken on any edge with enable=1 and in_valid=1; there is
  // no backpressure. enable=0 freezes every register, outputs included, and valids travel
  // with their data. out_valid marks the cycle a result is new; result/flags hold otherwise.

  logic              r0_valid, r0_sign, r0_shx;
  logic [1:0]        r0_mode;
  logic [54:0]       r0_mant;
  logic [EXP_W-1:0]  r0_exp;

  logic              r1_valid, r1_sign, r1_zero, r1_inc, r1_inexact, r1_tiny, r1_ovf_in;
  round_mode_e       r1_mode;
  logic [52:0]       r1_sig;
  logic [EXP_W-1:0]  r1_exp;

  logic              r2_valid, r2_sign, r2_zero, r2_ovf, r2_inexact, r2_tiny;
  round_mode_e       r2_mode;
  logic [10:0]       r2_exp;
  logic [51:0]       r2_frac;

  logic              w_inc, w_carry, w_promote, w_away, w_unused;
  logic [51:0]       w_frac;
  logic [EXP_W:0]    w_exp_final;
  logic [63:0]       w_result;
  logic [2:0]        w_flags;

  assign w_unused = mantissa_in[55] ^ (LATENCY != 3);

  fpu_round_incr u_incr (
    .i_round_mode (r0_mode),
    .i_sign       (r0_sign),
    .i_lsb        (r0_mant[2]),
    .i_guard      (r0_mant[1]),
    .i_sticky     (r0_mant[0]),
    .o_inc        (w_inc),
    .i_sig        (r1_sig),
    .i_inc        (r1_inc),
    .i_exp_zero   (r1_exp == '0),
    .o_frac       (w_frac),
    .o_carry      (w_carry),
    .o_promote    (w_promote)
  );

  assign w_exp_final = w_promote ? (EXP_W+1)'(1)
                                 : {1'b0, r1_exp} + {{EXP_W{1'b0}}, w_carry};

  always_comb begin
    w_away   = (r2_mode == RNE) | ((r2_mode == RUP) & ~r2_sign) | ((r2_mode == RDN) & r2_sign);
    w_result = {r2_sign, r2_exp, r2_frac};
    w_flags  = {1'b0, r2_inexact & r2_tiny, r2_inexact};
    if (r2_zero) begin
      w_result = {r2_sign, 63'b0};
      w_flags  = 3'b000;
    end else if (r2_ovf) begin
      w_result = w_away ? {r2_sign, EXP_MAX, {FRAC_W{1'b0}}}
                        : {r2_sign, EXP_MAXFIN, {FRAC_W{1'b1}}};
      w_flags  = 3'b101;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r0_valid      <= 1'b0;
      r1_valid      <= 1'b0;
      r2_valid      <= 1'b0;
      out_valid     <= 1'b0;
      result        <= 64'b0;
      out_inexact   <= 1'b0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
    end else if (enable) begin
      r0_valid <= in_valid;
      r0_mode  <= round_mode;
      r0_sign  <= sign_in;
      r0_mant  <= mantissa_in[54:0];
      r0_exp   <= exponent_in;
      r0_shx   <= shift_inexact_in;

      r1_valid   <= r0_valid;
      r1_mode    <= round_mode_e'(r0_mode);
      r1_sign    <= r0_sign;
      r1_zero    <= (r0_mant == 55'b0);
      r1_sig     <= r0_mant[54:2];
      r1_inc     <= w_inc;
      r1_exp     <= r0_exp;
      r1_inexact <= r0_mant[1] | r0_mant[0] | r0_shx;
      r1_tiny    <= (r0_exp == '0);
      r1_ovf_in  <= (r0_exp >= EXP_W'(2047));

      r2_valid   <= r1_valid;
      r2_mode    <= r1_mode;
      r2_sign    <= r1_sign;
      r2_zero    <= r1_zero;
      r2_frac    <= w_frac;
      r2_exp     <= w_exp_final[10:0];
      r2_ovf     <= r1_ovf_in | (w_exp_final >= (EXP_W+1)'(2047));
      r2_inexact <= r1_inexact;
      r2_tiny    <= r1_tiny;

      out_valid <= r2_valid;
      if (r2_valid) begin
        result        <= w_result;
        out_inexact   <= w_flags[FLAG_IX];
        out_overflow  <= w_flags[FLAG_OV];
        out_underflow <= w_flags[FLAG_UF];
      end
    end
  end

`ifdef FPU_ROUND_FLAGS_ACC_EN
  logic [2:0] r_flags_acc;
  logic [2:0] w_acc_next;

  // Clear happens first, so a result landing on the clearing edge is still recorded.
  always_comb begin
    w_acc_next = flags_clr ? 3'b000 : r_flags_acc;
    if (enable && r2_valid) w_acc_next = w_acc_next | w_flags;
  end

  always_ff @(posedge clk) begin
    if (rst) r_flags_acc <= 3'b000;
    else     r_flags_acc <= w_acc_next;
  end

  assign flags_acc = r_flags_acc;
`endif

endmodule

// File: tb/tb_fpu_round_pack.sv
// Directed vector bench for fpu_round_pack: pipelined table plus stall, reset and
// (with FPU_ROUND_FLAGS_ACC_EN) flag-accumulator sequences.
module tb_fpu_round_pack;

  logic        clk = 1'b0;
  logic        rst, enable, in_valid, sign_in, shift_inexact_in;
  logic [1:0]  round_mode;
  logic [55:0] mantissa_in;
  logic [11:0] exponent_in;
  logic        out_valid, out_inexact, out_overflow, out_underflow;
  logic [63:0] result;
`ifdef FPU_ROUND_FLAGS_ACC_EN
  logic        flags_clr;
  logic [2:0]  flags_acc;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [1:0]  mode;
    logic        sign;
    logic [55:0] mant;
    logic [11:0] exp;
    logic        shx;
    logic [63:0] res;
    logic [2:0]  flags;  // {inexact, overflow, underflow}
  } vec_t;

  vec_t vecs[16];
  int   n_vec;

  always #5 clk = ~clk;

  fpu_round_pack dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .in_valid         (in_valid),
    .round_mode       (round_mode),
    .sign_in          (sign_in),
    .mantissa_in      (mantissa_in),
    .exponent_in      (exponent_in),
    .shift_inexact_in (shift_inexact_in),
    .out_valid        (out_valid),
    .result           (result),
    .out_inexact      (out_inexact),
    .out_overflow     (out_overflow),
    .out_underflow    (out_underflow)
`ifdef FPU_ROUND_FLAGS_ACC_EN
    ,
    .flags_clr        (flags_clr),
    .flags_acc        (flags_acc)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_valid         = 1'b1;
    round_mode       = v.mode;
    sign_in          = v.sign;
    mantissa_in      = v.mant;
    exponent_in      = v.exp;
    shift_inexact_in = v.shx;
  endtask

  task automatic check_vec(input vec_t v);
    check({v.name, "_valid"}, {63'b0, out_valid}, 64'd1);
    check({v.name, "_result"}, result, v.res);
    check({v.name, "_flags"}, {61'b0, out_inexact, out_overflow, out_underflow},
          {61'b0, v.flags});
  endtask

  task automatic add(input string name, input logic [1:0] mode, input logic sign,
                     input logic [55:0] mant, input logic [11:0] exp, input logic shx,
                     input logic [63:0] res, input logic [2:0] flags);
    vecs[n_vec] = '{name, mode, sign, mant, exp, shx, res, flags};
    n_vec++;
  endtask

  initial begin
    n_vec = 0;
    add("one",        2'b00, 1'b0, 56'h40000000000000, 12'h3FF, 1'b0, 64'h3FF0000000000000, 3'b000);
    add("tie_up",     2'b00, 1'b0, 56'h40000000000006, 12'h3FF, 1'b0, 64'h3FF0000000000002, 3'b100);
    add("tie_even",   2'b00, 1'b0, 56'h40000000000002, 12'h3FF, 1'b0, 64'h3FF0000000000000, 3'b100);
    add("above_half", 2'b00, 1'b0, 56'h40000000000003, 12'h3FF, 1'b0, 64'h3FF0000000000001, 3'b100);
    add("carry",      2'b00, 1'b0, 56'h7FFFFFFFFFFFFE, 12'h3FF, 1'b0, 64'h4000000000000000, 3'b100);
    add("carry_ovf",  2'b00, 1'b0, 56'h7FFFFFFFFFFFFE, 12'h7FE, 1'b0, 64'h7FF0000000000000, 3'b110);
    add("rtz_max",    2'b01, 1'b0, 56'h7FFFFFFFFFFFFE, 12'h7FE, 1'b0, 64'h7FEFFFFFFFFFFFFF, 3'b100);
    add("rtz_trunc",  2'b01, 1'b0, 56'h7FFFFFFFFFFFFE, 12'h3FF, 1'b0, 64'h3FFFFFFFFFFFFFFF, 3'b100);
    add("denorm",     2'b00, 1'b0, 56'h00000000000004, 12'h000, 1'b1, 64'h0000000000000001, 3'b101);
    add("promote",    2'b00, 1'b0, 56'h3FFFFFFFFFFFFE, 12'h000, 1'b0, 64'h0010000000000000, 3'b101);
    add("neg_zero",   2'b00, 1'b1, 56'h00000000000000, 12'h000, 1'b0, 64'h8000000000000000, 3'b000);
    add("rup_pos",    2'b10, 1'b0, 56'h40000000000001, 12'h3FF, 1'b0, 64'h3FF0000000000001, 3'b100);
    add("rdn_pos",    2'b11, 1'b0, 56'h40000000000001, 12'h3FF, 1'b0, 64'h3FF0000000000000, 3'b100);
    add("rup_neg_ov", 2'b10, 1'b1, 56'h40000000000000, 12'h7FF, 1'b0, 64'hFFEFFFFFFFFFFFFF, 3'b110);
    add("rdn_neg_ov", 2'b11, 1'b1, 56'h40000000000000, 12'h7FF, 1'b0, 64'hFFF0000000000000, 3'b110);
    add("neg_1p5",    2'b00, 1'b1, 56'h60000000000000, 12'h3FF, 1'b0, 64'hBFF8000000000000, 3'b000);

    rst = 1'b1; enable = 1'b1; in_valid = 1'b0; round_mode = 2'b00; sign_in = 1'b0;
    mantissa_in = '0; exponent_in = '0; shift_inexact_in = 1'b0;
`ifdef FPU_ROUND_FLAGS_ACC_EN
    flags_clr = 1'b0;
`endif
    step();
    step();
    check("reset_valid", {63'b0, out_valid}, 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_flags", {61'b0, out_inexact, out_overflow, out_underflow}, 64'd0);
    rst = 1'b0;

    // Back-to-back: vector e enters at loop edge e and is visible after edge e+3.
    for (int e = 0; e < n_vec + 3; e++) begin
      if (e < n_vec) drive(vecs[e]);
      else in_valid = 1'b0;
      step();
      if (e >= 3) check_vec(vecs[e-3]);
      else check("fill_valid", {63'b0, out_valid}, 64'd0);
    end
    in_valid = 1'b0;
    step();
    check("drain_valid", {63'b0, out_valid}, 64'd0);
    check("drain_hold_result", result, vecs[n_vec-1].res);

    // Two stall cycles after the first stage: result arrives on the fifth edge.
    drive(vecs[1]);
    step();
    in_valid = 1'b0;
    step();
    enable = 1'b0;
    step();
    step();
    enable = 1'b1;
    step();
    check("stall_early_valid", {63'b0, out_valid}, 64'd0);
    step();
    check_vec(vecs[1]);

    // Full stall holds the visible result even with a new bundle presented.
    enable = 1'b0;
    drive(vecs[10]);
    step();
    step();
    check_vec(vecs[1]);
    in_valid = 1'b0;
    enable = 1'b1;

    // Reset with a bundle in flight: nothing may emerge.
    drive(vecs[0]);
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_result", result, 64'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_mid_valid", {63'b0, out_valid}, 64'd0);
    end

`ifdef FPU_ROUND_FLAGS_ACC_EN
    check("acc_after_rst", {61'b0, flags_acc}, 64'd0);
    drive(vecs[2]);
    step();
    drive(vecs[5]);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("acc_sticky", {61'b0, flags_acc}, 64'b101);
    flags_clr = 1'b1;
    step();
    flags_clr = 1'b0;
    check("acc_clear", {61'b0, flags_acc}, 64'd0);

    // Clear on the edge the overflow result lands keeps only that result's flags.
    drive(vecs[5]);
    step();
    in_valid = 1'b0;
    step();
    step();
    flags_clr = 1'b1;
    step();
    flags_clr = 1'b0;
    check("acc_clr_coincident", {61'b0, flags_acc}, 64'b101);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_round_pack.md
Name: fpu_round_pack

Overview:
- Back end of the double-precision multiply path. Consumes the multiplier front end's output bundle: sign, 56-bit pre-round mantissa with sticky, 12-bit biased exponent, shift-inexact.
- Applies IEEE-754 rounding in one of four modes, handles rounding carry, overflow, denormals and zero, and packs the 64-bit result plus exception flags.
- 3-stage valid-tagged pipeline. A global enable stalls the whole pipeline.

Parameters:
- EXP_W, 12, width of the incoming biased exponent.
- MANT_W, 56, width of the incoming mantissa bundle.
- LATENCY, 3, pipeline depth. Fixed; documentation only.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  pipeline advance. 0 = every stage holds.
- in_valid  in  1  input bundle valid this cycle
- round_mode  in  2  00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (-inf)
- sign_in  in  1  result sign
- mantissa_in  in  56  [55]=0 pad; [54] hidden bit; [53:2] fraction; [1] guard; [0] sticky
- exponent_in  in  12  biased exponent; 0 = denormal/zero; >=2047 = overflow
- shift_inexact_in  in  1  bits lost in upstream denormal shift
- out_valid  out  1  result valid
- result  out  64  packed IEEE double
- out_inexact  out  1  inexact flag
- out_overflow  out  1  overflow flag
- out_underflow  out  1  underflow flag (tiny and inexact)

Behaviour:
- Reset: all stage valids, result, and all flags are 0 on the clock edge where rst=1. Reset overrides enable. Reset mid-flight discards all in-flight bundles; no out_valid until 3 enabled cycles after the next in_valid.
- Latency: bundle sampled with in_valid=1, enable=1 at edge N appears at edge N+3, provided enable stays 1. Each enable=0 cycle adds one cycle; the stalled state holds exactly, including outputs.
- Stage 1: register inputs.
  - zero = mantissa_in[54:0]==0.
  - lsb = m[2], g = m[1], s = m[0].
  - inc decision: RNE g&(s|lsb); RTZ 0; RUP (g|s)&~sign; RDN (g|s)&sign.
- Stage 2: 54-bit sum = {m[54:2]} + inc, carry retained.
  - Carry out of bit 54 (all ones): fraction=0, exponent+1.
  - exponent_in==0 and rounded bit 54 set (denormal rounds up to normal): exponent becomes 1.
- Stage 3: pack and flag.
  - Overflow condition: final exponent >=2047, or exponent_in >=2047.
  - RNE, or the mode rounding away from zero for this sign: result = ±inf (exp 7FF, frac 0).
  - RTZ, or the mode rounding toward zero for this sign: result = ±max finite (exp 7FE, frac all ones).
  - out_overflow=1 and out_inexact=1 in both overflow cases.
  - Zero: result = {sign,63'b0}, all flags 0. Sign preserved.
  - out_inexact = g | s | shift_inexact_in (when not zero and not overflow).
  - out_underflow = out_inexact & (exponent_in==0), evaluated before rounding (tininess before rounding).
- Flags and result are valid only with out_valid. They are held, not cleared, when out_valid=0.
- Back-to-back bundles accepted every enabled cycle; no bubbles required.

Optional Feature:
- Macro FPU_ROUND_FLAGS_ACC_EN.
- Defined: adds ports flags_clr (in, 1) and flags_acc (out, 3, {overflow, underflow, inexact}).
  - flags_acc is a sticky OR of flags from every out_valid result.
  - Reset to 0. flags_clr=1 clears it the next edge.
  - flags_clr coincident with an out_valid result: the register loads that result's flags only (clear, then accumulate).
- Undefined: ports and register absent. Per-result flags unchanged.

Decomposition:
- Package fpu_round_pkg: round_mode_e enum (RNE, RTZ, RUP, RDN), EXP_MAX=11'h7FF, EXP_MAXFIN=11'h7FE, FRAC_W=52, flag index constants.
- One sub-module, fpu_round_incr: combinational inc decision plus 54-bit increment with carry and denormal-promote detect. Instantiated in stages 1/2.

Test Plan:
- 1.0 value: exp 1023, m=1<<54, RNE, in_valid=1 -> 3 cycles later out_valid=1, result=64'h3FF0000000000000, all flags 0.
- Ties to even:
  - m=(1<<54)|(1<<2)|(1<<1), RNE -> 64'h3FF0000000000002, inexact=1.
  - Same with bit2=0 -> 64'h3FF0000000000000, inexact=1.
- Carry out: m[54:1] all ones, exp 1023, RNE -> 64'h4000000000000000, inexact=1.
  - Same with exp 2046 -> 64'h7FF0000000000000, overflow=1.
  - Same with exp 2046, RTZ -> 64'h7FEFFFFFFFFFFFFF.
- Denormal:
  - exp 0, m=(1<<2), shift_inexact_in=1, RNE -> 64'h0000000000000001, inexact=1, underflow=1.
  - exp 0, m[53:1] all ones, RNE -> 64'h0010000000000000.
- Zero and stall: sign 1, m=0 -> 64'h8000000000000000, flags 0.
  - Drop enable for 2 cycles mid-flight -> output appears 5 cycles after input, values unchanged.
  - rst mid-flight -> out_valid stays 0.
- With FPU_ROUND_FLAGS_ACC_EN: inexact then overflow results -> flags_acc=3'b101; flags_clr -> 3'b000 next edge.
